// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants and encodings for the AES-128 round sequencer
// Contents: round/width constants, round-key address limits, FSM state and datapath-op encodings.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_DW    = 128;
  localparam int RK_ADDR_W = 4;

  localparam logic [RK_ADDR_W-1:0] RK_ADDR_CIPHER = 4'd0;
  localparam logic [RK_ADDR_W-1:0] RK_ADDR_LAST   = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARK0  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } seq_state_e;

  // Update applied to the 128-bit block register on the next edge.
  typedef enum logic [2:0] {
    DP_HOLD  = 3'd0,
    DP_LOAD  = 3'd1,
    DP_ARK0  = 3'd2,
    DP_ROUND = 3'd3,
    DP_CLEAR = 3'd4
  } dp_op_e;

endpackage

// File: rtl/aes_seq_fsm.sv
// rtl/aes_seq_fsm.sv - control FSM and round counter for the AES-128 round sequencer
// Ports: clk/rst (async active-high); key_loaded, in_valid, out_ready in;
//        in_ready, out_valid, busy, abort (registered pulse), rnd_final, rk_addr, dp_op out.
module aes_seq_fsm
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_loaded,
  input  logic                 in_valid,
  input  logic                 out_ready,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 abort,
  output logic                 rnd_final,
  output logic [RK_ADDR_W-1:0] rk_addr,
  output dp_op_e               dp_op
);

  localparam logic [RK_ADDR_W-1:0] LAST_RND = RK_ADDR_W'(NR);

  seq_state_e           state_q, state_d;
  logic [RK_ADDR_W-1:0] cnt_q, cnt_d;
  logic                 abort_q, abort_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= RK_ADDR_CIPHER;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
    dp_op     = DP_HOLD;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rnd_final = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low during reset so nothing looks acceptable while rst is asserted.
        in_ready = key_loaded & ~rst;
        if (in_valid && in_ready) begin
          state_d = ST_ARK0;
          cnt_d   = RK_ADDR_CIPHER;
          dp_op   = DP_LOAD;
        end
      end
      ST_ARK0: begin
        busy = 1'b1;
        if (!key_loaded) begin
          state_d = ST_IDLE;
          cnt_d   = RK_ADDR_CIPHER;
          abort_d = 1'b1;
          dp_op   = DP_CLEAR;
        end else begin
          state_d = ST_ROUND;
          cnt_d   = 4'd1;
          dp_op   = DP_ARK0;
        end
      end
      ST_ROUND: begin
        busy      = 1'b1;
        rnd_final = (cnt_q == LAST_RND);
        if (!key_loaded) begin
          state_d = ST_IDLE;
          cnt_d   = RK_ADDR_CIPHER;
          abort_d = 1'b1;
          dp_op   = DP_CLEAR;
        end else begin
          dp_op = DP_ROUND;
          if (rnd_final) begin
            state_d = ST_OUT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_OUT: begin
        // Ciphertext is complete here, so key_loaded no longer matters.
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
          cnt_d   = RK_ADDR_CIPHER;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = RK_ADDR_CIPHER;
      end
    endcase
  end

  assign rk_addr = cnt_q;
  assign abort   = abort_q;

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - one AES-128 encryption per block over an external round function and round-key store
// Ports: clk/rst (async active-high); in_valid/in_ready/in_data plaintext; rk_addr/rk_data round-key read;
//        rnd_in/rnd_final/rnd_out round function; out_valid/out_ready/out_data ciphertext; busy; abort.
// Option: AES_SEQ_PERF_EN adds blk_count[15:0] and abort_count[7:0] saturating counters.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int DW = AES_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_loaded,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic [RK_ADDR_W-1:0] rk_addr,
  input  logic [DW-1:0]        rk_data,
  output logic [DW-1:0]        rnd_in,
  output logic                 rnd_final,
  input  logic [DW-1:0]        rnd_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic                 busy,
  output logic                 abort
`ifdef AES_SEQ_PERF_EN
  ,
  output logic [15:0]          blk_count,
  output logic [7:0]           abort_count
`endif
);

  dp_op_e        dp_op;
  logic [DW-1:0] blk_q, blk_d;

  aes_seq_fsm #(
    .NR(NR)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .key_loaded(key_loaded),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .busy      (busy),
    .abort     (abort),
    .rnd_final (rnd_final),
    .rk_addr   (rk_addr),
    .dp_op     (dp_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q <= '0;
    end else begin
      blk_q <= blk_d;
    end
  end

  always_comb begin
    blk_d = blk_q;
    case (dp_op)
      DP_LOAD:  blk_d = in_data;
      DP_ARK0:  blk_d = blk_q ^ rk_data;
      DP_ROUND: blk_d = rnd_out ^ rk_data;
      DP_CLEAR: blk_d = '0;
      default:  blk_d = blk_q;
    endcase
  end

  assign rnd_in   = blk_q;
  assign out_data = blk_q;

`ifdef AES_SEQ_PERF_EN
  logic [15:0] blk_count_q, blk_count_d;
  logic [7:0]  abort_count_q, abort_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_count_q   <= '0;
      abort_count_q <= '0;
    end else begin
      blk_count_q   <= blk_count_d;
      abort_count_q <= abort_count_d;
    end
  end

  always_comb begin
    blk_count_d   = blk_count_q;
    abort_count_d = abort_count_q;
    if (out_valid && out_ready && (blk_count_q != 16'hFFFF)) begin
      blk_count_d = blk_count_q + 16'd1;
    end
    if (abort && (abort_count_q != 8'hFF)) begin
      abort_count_d = abort_count_q + 8'd1;
    end
  end

  assign blk_count   = blk_count_q;
  assign abort_count = abort_count_q;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - self-checking bench for aes_round_sequencer with a behavioural AES-128 model
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_loaded;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic [127:0] rnd_in;
  logic         rnd_final;
  logic [127:0] rnd_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         abort;
`ifdef AES_SEQ_PERF_EN
  logic [15:0]  blk_count;
  logic [7:0]   abort_count;
`endif

  logic [127:0] rk_mem [0:15];
  logic [127:0] cur_key;
  int           n_checks = 0;
  int           n_fail   = 0;

  aes_round_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .key_loaded(key_loaded),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .rnd_in    (rnd_in),
    .rnd_final (rnd_final),
    .rnd_out   (rnd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .abort     (abort)
`ifdef AES_SEQ_PERF_EN
    ,
    .blk_count  (blk_count),
    .abort_count(abort_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural AES-128 ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a, y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01, b = x, e = 8'd254, v;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    v = r;
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(8'd2, a0) ^ gmul(8'd3, a1) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(8'd2, a1) ^ gmul(8'd3, a2) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(8'd2, a2) ^ gmul(8'd3, a3);
        t[4*c+3] = gmul(8'd3, a0) ^ a1 ^ a2 ^ gmul(8'd2, a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ round_key(key, 0);
    for (int r = 1; r <= 10; r++) s = aes_round(s, r == 10) ^ round_key(key, r);
    return s;
  endfunction

  // Environment: key store and external round function.
  assign rk_data = rk_mem[rk_addr];
  assign rnd_out = aes_round(rnd_in, rnd_final);

  task automatic load_key(input logic [127:0] k);
    for (int n = 0; n < 16; n++) rk_mem[n] = (n <= 10) ? round_key(k, n) : '0;
    cur_key = k;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents in_valid and waits (bounded) until the accepting edge has passed.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ok = in_ready;
      @(negedge clk);
      if (ok) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] pt, input int hold);
    logic [127:0] exp;
    bit ok;
    int lat;
    exp = aes_encrypt(pt, cur_key);
    in_data = pt;
    wait_accept(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL blk_accept: in_ready never seen, want accept"); end
    lat = 0;
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    n_checks++; if (lat != 11) begin n_fail++; $display("FAIL blk_latency: got %0d edges want 11", lat); end
    for (int h = 0; h < hold; h++) begin
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp) begin
        n_fail++; $display("FAIL blk_hold: ov=%0b ir=%0b data=%h want ov=1 ir=0 data=%h", out_valid, in_ready, out_data, exp); end
      @(negedge clk);
    end
    n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL blk_data: got %h want %h", out_data, exp); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL blk_release: ov=%0b ir=%0b want ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic do_abort(inout int timeouts);
    bit ok;
    key_loaded = 1'b1;
    in_data = rand128();
    wait_accept(ok);
    if (!ok) timeouts++;
    key_loaded = 1'b0;
    @(negedge clk);
    @(negedge clk);
    key_loaded = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if ({in_ready, out_valid, busy, abort, rnd_final} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {in_ready, out_valid, busy, abort, rnd_final}); end
    n_checks++; if (rk_addr !== 4'd0 || out_data !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: rk_addr=%0d data=%h want 0/0", rk_addr, out_data); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({in_ready, out_valid, busy, abort} !== 4'b0) begin
      n_fail++; $display("FAIL reset_release: got %b want 0000", {in_ready, out_valid, busy, abort}); end
  endtask

  task automatic test_fips();
    bit ok;
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    n_checks++; if (aes_encrypt(128'h00112233445566778899aabbccddeeff, cur_key) !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      n_fail++; $display("FAIL model_fips: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a",
                          aes_encrypt(128'h00112233445566778899aabbccddeeff, cur_key)); end
    key_loaded = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fips_in_ready: got %0b want 1", in_ready); end
    in_data = 128'h00112233445566778899aabbccddeeff;
    wait_accept(ok);
    for (int k = 0; k <= 10; k++) begin
      n_checks++; if (rk_addr !== 4'(k) || rnd_final !== (k == 10) || busy !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL fips_seq%0d: rk_addr=%0d fin=%0b busy=%0b ov=%0b want %0d/%0b/1/0",
                            k, rk_addr, rnd_final, busy, out_valid, k, k == 10); end
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      n_fail++; $display("FAIL fips_ct: ov=%0b data=%h want 1/69c4e0d86a7b0430d8cdb78070b4c55a", out_valid, out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    run_block(rand128(), 5);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      load_key(rand128());
      run_block(rand128(), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pa, pb, outs [2];
    int acc_cyc [2];
    int hs_cyc [2];
    int n_acc = 0, n_out = 0;
    pa = rand128(); pb = rand128();
    out_ready = 1'b1; in_valid = 1'b1; in_data = pa;
    for (int cyc = 0; cyc < 80 && n_out < 2; cyc++) begin
      if (out_valid && out_ready) begin outs[n_out] = out_data; hs_cyc[n_out] = cyc; n_out++; end
      if (in_valid && in_ready && n_acc < 2) begin acc_cyc[n_acc] = cyc; n_acc++; end
      @(negedge clk);
      if (n_acc == 1) in_data = pb;
      if (n_acc == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    n_checks++; if (n_out != 2 || n_acc != 2) begin
      n_fail++; $display("FAIL b2b_count: outputs=%0d accepts=%0d want 2/2", n_out, n_acc); end
    else begin
      n_checks++; if (outs[0] !== aes_encrypt(pa, cur_key) || outs[1] !== aes_encrypt(pb, cur_key)) begin
        n_fail++; $display("FAIL b2b_data: got %h %h want %h %h", outs[0], outs[1], aes_encrypt(pa, cur_key), aes_encrypt(pb, cur_key)); end
      n_checks++; if (acc_cyc[1] - hs_cyc[0] != 1 || acc_cyc[1] - acc_cyc[0] != 13) begin
        n_fail++; $display("FAIL b2b_timing: accept gap %0d, after handshake %0d want 13/1",
                            acc_cyc[1] - acc_cyc[0], acc_cyc[1] - hs_cyc[0]); end
    end
  endtask

  task automatic test_abort();
    bit ok;
    int aborts = 0, ovs = 0, busys = 0, w = 0;
    in_data = rand128();
    wait_accept(ok);
    in_valid = 1'b1;
    while (!(busy && rk_addr == 4'd5) && w < 20) begin @(negedge clk); w++; end
    n_checks++; if (w >= 20) begin n_fail++; $display("FAIL abort_reach: round 5 not seen want round 5"); end
    key_loaded = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      aborts += int'(abort); ovs += int'(out_valid); busys += int'(busy);
    end
    n_checks++; if (aborts != 1) begin n_fail++; $display("FAIL abort_pulse: got %0d cycles want 1", aborts); end
    n_checks++; if (ovs != 0 || busys != 0) begin n_fail++; $display("FAIL abort_idle: ov=%0d busy=%0d cycles want 0/0", ovs, busys); end
    n_checks++; if (in_ready !== 1'b0 || out_data !== 128'h0) begin
      n_fail++; $display("FAIL abort_state: ir=%0b data=%h want 0/0", in_ready, out_data); end
    in_valid = 1'b0; key_loaded = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_recover: ir=%0b want 1", in_ready); end
  endtask

  task automatic test_nokey_and_rst();
    bit ok;
    int w = 0, aborts = 0;
    key_loaded = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL nokey_%0d: ir=%0b busy=%0b want 0/0", i, in_ready, busy); end
    end
    in_valid = 1'b0; key_loaded = 1'b1;
    in_data = rand128();
    wait_accept(ok);
    while (!(busy && rk_addr == 4'd3) && w < 20) begin @(negedge clk); w++; end
    rst = 1'b1;
    #1;
    n_checks++; if ({in_ready, out_valid, busy, abort, rnd_final} !== 5'b0 || rk_addr !== 4'd0 || out_data !== 128'h0) begin
      n_fail++; $display("FAIL rst_mid: ctrl=%b rk_addr=%0d data=%h want 0", {in_ready, out_valid, busy, abort, rnd_final}, rk_addr, out_data); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); aborts += int'(abort) + int'(out_valid); end
    n_checks++; if (aborts != 0) begin n_fail++; $display("FAIL rst_noabort: got %0d abort/ov cycles want 0", aborts); end
  endtask

`ifdef AES_SEQ_PERF_EN
  task automatic test_perf();
    int timeouts = 0;
    for (int i = 0; i < 3; i++) run_block(rand128(), 0);
    do_abort(timeouts);
    @(negedge clk);
    n_checks++; if (blk_count !== 16'd3 || abort_count !== 8'd1) begin
      n_fail++; $display("FAIL perf_count: blk=%0d abort=%0d want 3/1", blk_count, abort_count); end
    for (int i = 0; i < 260; i++) do_abort(timeouts);
    @(negedge clk);
    n_checks++; if (abort_count !== 8'hFF || blk_count !== 16'd3 || timeouts != 0) begin
      n_fail++; $display("FAIL perf_sat: abort=%h blk=%0d timeouts=%0d want FF/3/0", abort_count, blk_count, timeouts); end
  endtask
`endif

  initial begin
    rst = 1'b1; key_loaded = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    load_key('0);
    test_reset();
    test_fips();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_abort();
    test_nokey_and_rst();
`ifdef AES_SEQ_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
